// File: rtl/disp_color_sched.sv
// ---------------------------------------------------------------------------
// disp_color_sched
//
// Frame-synchronous colour scheduler for the VGA display path.
// Requesters ask for a new fill colour and are granted round-robin. Each
// winning colour is parked in a shadow register. The shadow is copied into
// the display colour only at the start of the vertical sync pulse, so a
// colour change never lands mid-frame.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   CW          colour width, packed {R,G,B}
//   DEFAULT_COL colour driven out of reset
//
// Ports
//   clk        in   pixel-domain clock
//   rst_n      in   synchronous, active-low reset
//   req        in   [NREQ]      per-requester request level
//   req_col    in   [NREQ*CW]   requester i colour at [i*CW +: CW]
//   vsync      in   display vsync (active-low pulse), already in clk domain
//   gnt        out  [NREQ]      one-hot, one-cycle grant pulse
//   col        out  [CW]        colour to display block
//   pending    out  shadow holds a colour not yet committed
//   commit     out  one-cycle pulse when col is updated
//   frame_cnt  out  [8]         count of vsync falling edges, wraps
//
// Handshake: a requester raises req[i] and holds req_col[i] stable until it
// sees gnt[i] high. It must drop req[i] by the next clock edge; a req[i]
// still high at that edge is a fresh request. Dropping req before a grant
// withdraws the request and leaves no state behind.
// ---------------------------------------------------------------------------
module disp_color_sched #(
  parameter int          NREQ        = 4,
  parameter int          CW          = 12,
  parameter logic [CW-1:0] DEFAULT_COL = 12'h0F0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_col,
  input  logic               vsync,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      col,
  output logic               pending,
  output logic               commit,
  output logic [7:0]         frame_cnt
);

  localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  logic [PW-1:0] ptr;
  logic [CW-1:0] shadow;
  logic          vs_q;
  logic          edge_q;

  // Arbitration result for this cycle
  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;
  logic [PW-1:0] ptr_nxt;
  logic [CW-1:0] win_col;

  // Rotating priority search starting at ptr; first asserted req wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_vld && req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    win_col = req_col[int'(win_idx)*CW +: CW];
  end

  // The falling edge of vsync is registered once before it acts, so the
  // commit happens one cycle after the falling transition is sampled.
  // The commit reads shadow before this cycle's grant overwrites it, so
  // an edge and a grant in the same cycle commit the old colour and keep
  // the new one pending for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      shadow    <= DEFAULT_COL;
      col       <= DEFAULT_COL;
      gnt       <= '0;
      pending   <= 1'b0;
      commit    <= 1'b0;
      frame_cnt <= 8'd0;
      vs_q      <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      vs_q   <= vsync;
      edge_q <= vs_q & ~vsync;

      gnt <= win_vld ? (NREQ'(1) << win_idx) : '0;
      if (win_vld) begin
        shadow <= win_col;
        ptr    <= ptr_nxt;
      end

      if (edge_q) frame_cnt <= frame_cnt + 8'd1;

      commit <= edge_q & pending;
      if (edge_q && pending) col <= shadow;

      pending <= win_vld | (pending & ~edge_q);
    end
  end

endmodule

// File: tb/tb_disp_color_sched.sv
// ---------------------------------------------------------------------------
// tb_disp_color_sched
// Directed bench for disp_color_sched (NREQ=4, CW=12, DEFAULT_COL=0x0F0).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. just after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_disp_color_sched;

  localparam int NREQ = 4;
  localparam int CW   = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] req_col;
  logic               vsync;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      col;
  logic               pending;
  logic               commit;
  logic [7:0]         frame_cnt;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_frames = 8'd0;

  disp_color_sched #(.NREQ(NREQ), .CW(CW), .DEFAULT_COL(12'h0F0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_col   (req_col),
    .vsync     (vsync),
    .gnt       (gnt),
    .col       (col),
    .pending   (pending),
    .commit    (commit),
    .frame_cnt (frame_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync low pulse. Reports commit/col/pending on the cycle the commit
  // is due, and whether commit showed up on the cycle before or after it.
  task automatic frame(output logic c_at, output logic c_other,
                       output logic [CW-1:0] col_at, output logic pend_at);
    vsync = 1'b0;
    step();
    c_other = commit;
    step();
    c_at    = commit;
    col_at  = col;
    pend_at = pending;
    vsync = 1'b1;
    step();
    c_other = c_other | commit;
    step();
    exp_frames = exp_frames + 8'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_col = '0; vsync = 1'b1;
    step(); step();
    vec_cnt++; if (col !== 12'h0F0) begin err_cnt++; $display("FAIL reset_col: got %h want 0f0", col); end
    vec_cnt++; if (pending !== 1'b0) begin err_cnt++; $display("FAIL reset_pending: got %b want 0", pending); end
    vec_cnt++; if (commit !== 1'b0) begin err_cnt++; $display("FAIL reset_commit: got %b want 0", commit); end
    vec_cnt++; if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vec_cnt++; if (frame_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    exp_frames = 8'd0;
    step(); step();
  endtask

  task automatic test_idle_frames();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    for (int f = 0; f < 256; f++) begin
      frame(c_at, c_other, cv, p);
      vec_cnt++; if (frame_cnt !== exp_frames) begin err_cnt++; $display("FAIL idle_frame_cnt f=%0d: got %0d want %0d", f, frame_cnt, exp_frames); end
      vec_cnt++; if ((cv !== 12'h0F0) || (p !== 1'b0) || (c_at !== 1'b0) || (c_other !== 1'b0)) begin
        err_cnt++; $display("FAIL idle_state f=%0d: col %h pend %b commit %b/%b want 0f0 0 0/0", f, cv, p, c_at, c_other);
      end
    end
    // 256 edges since reset: counter must have wrapped to zero
    vec_cnt++; if (frame_cnt !== 8'd0) begin err_cnt++; $display("FAIL idle_wrap: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_single();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    step();
    req = 4'b0100; req_col[2*CW +: CW] = 12'hF00;
    step();
    vec_cnt++; if (gnt !== 4'b0100) begin err_cnt++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    req = '0;
    step();
    vec_cnt++; if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt); end
    vec_cnt++; if (pending !== 1'b1) begin err_cnt++; $display("FAIL single_pending: got %b want 1", pending); end
    vec_cnt++; if (col !== 12'h0F0) begin err_cnt++; $display("FAIL single_col_hold: got %h want 0f0", col); end
    frame(c_at, c_other, cv, p);
    vec_cnt++; if (c_at !== 1'b1) begin err_cnt++; $display("FAIL single_commit: got %b want 1", c_at); end
    vec_cnt++; if (c_other !== 1'b0) begin err_cnt++; $display("FAIL single_commit_width: got %b want 0", c_other); end
    vec_cnt++; if (cv !== 12'hF00) begin err_cnt++; $display("FAIL single_col: got %h want f00", cv); end
    vec_cnt++; if (p !== 1'b0) begin err_cnt++; $display("FAIL single_pending_clr: got %b want 0", p); end
    vec_cnt++; if (frame_cnt !== exp_frames) begin err_cnt++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    rst_n = 1'b0;
    req = 4'b1011;
    req_col[0*CW +: CW] = 12'h00F;
    req_col[1*CW +: CW] = 12'h0FF;
    req_col[3*CW +: CW] = 12'hFFF;
    step(); step();
    vec_cnt++; if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL b2b_gnt_in_reset: got %b want 0000", gnt); end
    rst_n = 1'b1;
    exp_frames = 8'd0;
    step();
    vec_cnt++; if (gnt !== 4'b0001) begin err_cnt++; $display("FAIL b2b_gnt0: got %b want 0001", gnt); end
    req[0] = 1'b0;
    step();
    vec_cnt++; if (gnt !== 4'b0010) begin err_cnt++; $display("FAIL b2b_gnt1: got %b want 0010", gnt); end
    req[1] = 1'b0;
    step();
    vec_cnt++; if (gnt !== 4'b1000) begin err_cnt++; $display("FAIL b2b_gnt3: got %b want 1000", gnt); end
    req[3] = 1'b0;
    step();
    vec_cnt++; if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL b2b_idle: got %b want 0000", gnt); end
    vec_cnt++; if (col !== 12'h0F0) begin err_cnt++; $display("FAIL b2b_col_hold: got %h want 0f0", col); end
    frame(c_at, c_other, cv, p);
    vec_cnt++; if ((c_at !== 1'b1) || (cv !== 12'hFFF) || (p !== 1'b0)) begin
      err_cnt++; $display("FAIL b2b_commit: commit %b col %h pend %b want 1 fff 0", c_at, cv, p);
    end
  endtask

  task automatic test_edge_grant();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    // ptr is 0 after the grant to requester 3
    req = 4'b0100; req_col[2*CW +: CW] = 12'hF00;
    step();
    req = '0;
    step();
    vec_cnt++; if (pending !== 1'b1) begin err_cnt++; $display("FAIL eg_pending_pre: got %b want 1", pending); end
    vsync = 1'b0;
    step();
    // next edge is the commit cycle; land a grant on it
    req = 4'b0001; req_col[0*CW +: CW] = 12'h00F;
    step();
    vec_cnt++; if (commit !== 1'b1) begin err_cnt++; $display("FAIL eg_commit: got %b want 1", commit); end
    vec_cnt++; if (col !== 12'hF00) begin err_cnt++; $display("FAIL eg_col_old: got %h want f00", col); end
    vec_cnt++; if (gnt !== 4'b0001) begin err_cnt++; $display("FAIL eg_gnt: got %b want 0001", gnt); end
    vec_cnt++; if (pending !== 1'b1) begin err_cnt++; $display("FAIL eg_pending_kept: got %b want 1", pending); end
    req = '0; vsync = 1'b1;
    step();
    vec_cnt++; if ((commit !== 1'b0) || (col !== 12'hF00) || (pending !== 1'b1)) begin
      err_cnt++; $display("FAIL eg_after: commit %b col %h pend %b want 0 f00 1", commit, col, pending);
    end
    step();
    exp_frames = exp_frames + 8'd1;
    frame(c_at, c_other, cv, p);
    vec_cnt++; if ((c_at !== 1'b1) || (cv !== 12'h00F) || (p !== 1'b0)) begin
      err_cnt++; $display("FAIL eg_next_frame: commit %b col %h pend %b want 1 00f 0", c_at, cv, p);
    end
    vec_cnt++; if (frame_cnt !== exp_frames) begin err_cnt++; $display("FAIL eg_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_latest_wins();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    // ptr is 1 after the grant to requester 0
    req = 4'b0010; req_col[1*CW +: CW] = 12'h123;
    step();
    vec_cnt++; if (gnt !== 4'b0010) begin err_cnt++; $display("FAIL lw_gnt1: got %b want 0010", gnt); end
    req = 4'b0100; req_col[2*CW +: CW] = 12'h456;
    step();
    vec_cnt++; if (gnt !== 4'b0100) begin err_cnt++; $display("FAIL lw_gnt2: got %b want 0100", gnt); end
    req = '0;
    step();
    frame(c_at, c_other, cv, p);
    vec_cnt++; if ((c_at !== 1'b1) || (cv !== 12'h456)) begin
      err_cnt++; $display("FAIL lw_commit: commit %b col %h want 1 456", c_at, cv);
    end
  endtask

  task automatic test_reset_mid_pending();
    logic c_at, c_other, p;
    logic [CW-1:0] cv;
    // ptr is 3 after the grant to requester 2; requester 3 takes 0xABC
    req = 4'b1000; req_col[3*CW +: CW] = 12'hABC;
    step();
    req = '0;
    step();
    vec_cnt++; if (pending !== 1'b1) begin err_cnt++; $display("FAIL rmp_pending_pre: got %b want 1", pending); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_frames = 8'd0;
    vec_cnt++; if ((col !== 12'h0F0) || (pending !== 1'b0) || (frame_cnt !== 8'd0)) begin
      err_cnt++; $display("FAIL rmp_reset: col %h pend %b fc %0d want 0f0 0 0", col, pending, frame_cnt);
    end
    step();
    frame(c_at, c_other, cv, p);
    vec_cnt++; if ((c_at !== 1'b0) || (c_other !== 1'b0) || (cv !== 12'h0F0) || (p !== 1'b0)) begin
      err_cnt++; $display("FAIL rmp_no_commit: commit %b/%b col %h pend %b want 0/0 0f0 0", c_at, c_other, cv, p);
    end
    vec_cnt++; if (frame_cnt !== exp_frames) begin err_cnt++; $display("FAIL rmp_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    // pointer back at 0: all requesting, requester 0 must win
    req = 4'b1111;
    step();
    vec_cnt++; if (gnt !== 4'b0001) begin err_cnt++; $display("FAIL rmp_ptr: got %b want 0001", gnt); end
    req = 4'b1110;
    step();
    vec_cnt++; if (gnt !== 4'b0010) begin err_cnt++; $display("FAIL rmp_ptr_next: got %b want 0010", gnt); end
    req = '0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_frames();
    test_single();
    test_back_to_back();
    test_edge_grant();
    test_latest_wins();
    test_reset_mid_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/disp_color_sched.md
# disp_color_sched

Frame-synchronous colour scheduler for the VGA display path. It arbitrates up to NREQ requesters (switch logic, button handlers, pattern engines) that want to change the single fill colour driven into the display block. It grants requesters round-robin and holds the winning colour in a shadow register. The shadow is committed to the display colour only at the start of the vertical sync pulse, so a colour change never tears mid-frame.

## Interface
- NREQ, 4: number of requesters, 2..8
- CW, 12: colour width, packed {R[3:0],G[3:0],B[3:0]}
- DEFAULT_COL, 12'h0F0: colour driven out of reset
- clk  in  1  system pixel-domain clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  NREQ  per-requester request level; held until that requester's gnt bit is seen
- req_col  in  NREQ*CW  requester i's colour at bits [i*CW +: CW]
- vsync  in  1  display Vsync (active-low pulse), already in clk domain
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- col  out  CW  colour to display block
- pending  out  1  shadow holds an uncommitted colour
- commit  out  1  one-cycle pulse when col is updated
- frame_cnt  out  8  count of vsync falling edges, wraps 255->0

## Operation
- Reset (rst_n low at a clk edge) forces the following values:
  - col = DEFAULT_COL; shadow = DEFAULT_COL
  - gnt = 0, pending = 0, commit = 0, frame_cnt = 0
  - rr pointer = 0; vs_q = 0
- Reset aborts any pending colour. That colour is discarded and is never committed.
- Arbitration runs every cycle, independent of pending:
  - Search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. The first asserted req bit wins.
  - On a win by requester w: shadow <= req_col[w], pending <= 1, gnt <= one-hot(w), ptr <= (w+1) mod NREQ.
  - With no req asserted: gnt <= 0, and ptr and shadow are unchanged.
- Latest-wins: a grant while pending = 1 overwrites the shadow. The earlier colour is dropped silently.
- Frame edge: edge = vs_q & ~vsync, with vs_q <= vsync every cycle.
  - frame_cnt increments on every edge, whether or not a colour is pending.
- Commit on an edge with pending = 1:
  - col <= shadow value held before this cycle's arbitration update
  - commit <= 1 for one cycle
  - pending <= 0, unless a grant occurs in the same cycle
- Edge and grant in the same cycle:
  - The old shadow commits.
  - The new colour loads into the shadow.
  - pending stays 1, and the new colour commits at the next frame edge.
- Edge with pending = 0: col is unchanged and commit stays 0.
- A requester that drops req before its grant simply loses arbitration. No state is left behind.

## Timing
- Grant latency: req sampled at edge N gives gnt high during cycle N+1 only.
- The requester must deassert req by the edge after it sees gnt. If req is still high at that edge, it is treated as a new request.
- Commit latency: the vsync falling transition is sampled at edge M. At edge M+1, col updates and commit pulses.
  - Precisely: vs_q = 1 and vsync = 0 at edge M cause col and commit to update at M+1, because edge is registered once.
- All outputs are registered. There are no combinational paths from input to output.
- Max throughput is one grant per cycle. Each requester is guaranteed a grant within NREQ cycles of asserting req.
- The first edge after reset requires vsync to be observed high at least once first, because vs_q resets to 0.

## Test plan
- Reset then idle, vsync toggling at frame rate:
  - col = 0x0F0 and pending = 0 throughout.
  - frame_cnt counts edges and wraps from 255 to 0 after 256 frames.
- Single request, req[2] with colour 0xF00 mid-frame:
  - gnt = 4'b0100 for one cycle, then pending = 1.
  - col stays 0x0F0 until the next vsync fall, then becomes 0xF00 with a one-cycle commit pulse and pending = 0.
- req[0], req[1], req[3] held from reset (colours 0x00F, 0x0FF, 0xFFF):
  - Grants arrive in order 0, 1, 3 on consecutive cycles, each dropped after its gnt.
  - Next commit is 0xFFF.
- Grant in the same cycle as the frame edge:
  - Shadow holds 0xF00; a request for 0x00F is granted on the edge cycle.
  - col becomes 0xF00 and pending stays 1.
  - Next frame: col becomes 0x00F and pending becomes 0.
- Reset mid-pending: shadow = 0xABC with pending = 1, then rst_n pulsed low for one cycle.
  - col returns to 0x0F0 and stays there across the next frame edge.
  - pending = 0 and ptr = 0.
